grf_wb_arbiter: RTL and testbench

//  Owns the single GRF write port. Arbitrates between the in-order pipeline writeback (pipe) and the long-latency unit (lu),

---
 rtl/grf_wb_pkg.sv | 22 ++
 rtl/grf_scoreboard.sv | 44 ++++
 rtl/grf_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_grf_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_pkg.sv
// grf_wb_pkg: shared widths, the register-zero constant and the source tag
// carried next to the registered GRF write beat.
package grf_wb_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        SRC_PIPE = 1'b0,
        SRC_LU   = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic              we;
        wb_src_e           src;
        logic [REG_W-1:0]  aw;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_beat_t;
endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: one busy bit per GRF register for destinations whose write
// is still pending in the long-latency unit.
//   clk, reset       clock, synchronous active-high reset
//   set_en_i/aw_i    mark a destination busy (issue allocation)
//   clr_en_i/aw_i    release a destination (lu beat committed on the GRF port)
//   rs_i, rt_i       source lookups       -> rs_busy_o, rt_busy_o
//   waw_aw_i         destination lookup   -> waw_busy_o
// Register 0 is never busy.
module grf_scoreboard
    import grf_wb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en_i,
    input  logic [REG_W-1:0] set_aw_i,
    input  logic             clr_en_i,
    input  logic [REG_W-1:0] clr_aw_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic [REG_W-1:0] waw_aw_i,
    output logic             rs_busy_o,
    output logic             rt_busy_o,
    output logic             waw_busy_o
);
    logic [NREG-1:0] busy_q, busy_d;

    // Clear is applied before set so a same-edge re-allocation survives:
    // the new pending write is younger than the one committing.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_aw_i] = 1'b0;
        if (set_en_i && set_aw_i != REG_ZERO) busy_d[set_aw_i] = 1'b1;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign rs_busy_o  = (rs_i     != REG_ZERO) & busy_q[rs_i];
    assign rt_busy_o  = (rt_i     != REG_ZERO) & busy_q[rt_i];
    assign waw_busy_o = (waw_aw_i != REG_ZERO) & busy_q[waw_aw_i];
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: owner of the single GRF write port.
// Arbitrates pipe writeback against the long-latency unit (lu), registers the
// winning beat onto grf_* one cycle after acceptance, and tracks lu-pending
// destinations so issue stalls on RAW/WAW hazards.
//   clk, reset                  clock, synchronous active-high reset
//   pipe_valid/ready/aw/wd/pc   pipe writeback beat
//   lu_valid/ready/aw/wd/pc     long-latency unit result beat
//   iss_alloc/aw/rs/rt          issue-stage allocation and source lookup
//   iss_hazard                  issue must stall this cycle (combinational)
//   grf_we/aw/wd/pc             registered GRF write port
// Build option: GRF_WB_STARVE_EN enables the lu starvation guard (lu is forced
// to win after STARVE_MAX consecutive losses). Without it pipe has strict
// priority and lu waits indefinitely while pipe_valid is high.
module grf_wb_arbiter
    import grf_wb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_valid,
    output logic              pipe_ready,
    input  logic [REG_W-1:0]  pipe_aw,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic [DATA_W-1:0] pipe_pc,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_W-1:0]  lu_aw,
    input  logic [DATA_W-1:0] lu_wd,
    input  logic [DATA_W-1:0] lu_pc,
    input  logic              iss_alloc,
    input  logic [REG_W-1:0]  iss_aw,
    input  logic [REG_W-1:0]  iss_rs,
    input  logic [REG_W-1:0]  iss_rt,
    output logic              iss_hazard,
    output logic              grf_we,
    output logic [REG_W-1:0]  grf_aw,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc
);
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be within 1..15");
    end

    wb_beat_t out_q, out_d;
    logic     rs_busy, rt_busy, waw_busy;

`ifdef GRF_WB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic       lu_force;

    assign lu_force   = lu_valid & (starve_q == STARVE_LIM);
    assign pipe_ready = pipe_valid & ~lu_force;

    // Counts consecutive cycles lu was offered and lost; any lu acceptance or
    // idle lu resets the run.
    always_comb begin
        starve_d = 4'd0;
        if (lu_valid && !lu_ready)
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) starve_q <= 4'd0;
        else       starve_q <= starve_d;
    end
`else
    assign pipe_ready = pipe_valid;
`endif

    assign lu_ready = lu_valid & ~pipe_ready;

    // Accepted beats to $0 complete the handshake but never write.
    always_comb begin
        out_d    = out_q;
        out_d.we = 1'b0;
        if (pipe_ready) begin
            out_d.we  = (pipe_aw != REG_ZERO);
            out_d.src = SRC_PIPE;
            out_d.aw  = pipe_aw;
            out_d.wd  = pipe_wd;
            out_d.pc  = pipe_pc;
        end else if (lu_ready) begin
            out_d.we  = (lu_aw != REG_ZERO);
            out_d.src = SRC_LU;
            out_d.aw  = lu_aw;
            out_d.wd  = lu_wd;
            out_d.pc  = lu_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

    assign grf_we = out_q.we;
    assign grf_aw = out_q.aw;
    assign grf_wd = out_q.wd;
    assign grf_pc = out_q.pc;

    grf_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en_i   (iss_alloc & ~iss_hazard),
        .set_aw_i   (iss_aw),
        .clr_en_i   (out_q.we & (out_q.src == SRC_LU)),
        .clr_aw_i   (out_q.aw),
        .rs_i       (iss_rs),
        .rt_i       (iss_rt),
        .waw_aw_i   (iss_aw),
        .rs_busy_o  (rs_busy),
        .rt_busy_o  (rt_busy),
        .waw_busy_o (waw_busy)
    );

    assign iss_hazard = rs_busy | rt_busy | (iss_alloc & waw_busy);
endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid, pipe_ready;
    logic [4:0]  pipe_aw;
    logic [31:0] pipe_wd, pipe_pc;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_aw;
    logic [31:0] lu_wd, lu_pc;
    logic        iss_alloc, iss_hazard;
    logic [4:0]  iss_aw, iss_rs, iss_rt;
    logic        grf_we;
    logic [4:0]  grf_aw;
    logic [31:0] grf_wd, grf_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [4:0]  aw;
        logic [31:0] wd;
        logic [31:0] pc;
        int          due;
    } beat_t;
    beat_t exp_q[$];

    grf_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_valid (pipe_valid),
        .pipe_ready (pipe_ready),
        .pipe_aw    (pipe_aw),
        .pipe_wd    (pipe_wd),
        .pipe_pc    (pipe_pc),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_aw      (lu_aw),
        .lu_wd      (lu_wd),
        .lu_pc      (lu_pc),
        .iss_alloc  (iss_alloc),
        .iss_aw     (iss_aw),
        .iss_rs     (iss_rs),
        .iss_rt     (iss_rt),
        .iss_hazard (iss_hazard),
        .grf_we     (grf_we),
        .grf_aw     (grf_aw),
        .grf_wd     (grf_wd),
        .grf_pc     (grf_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every GRF write must match the oldest expected beat, in the
    // cycle right after its acceptance.
    always @(negedge clk) begin
        beat_t b;
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_write actual=none required=aw%0d (due %0d, cycle %0d)",
                     exp_q[0].aw, exp_q[0].due, cyc);
            void'(exp_q.pop_front());
        end
        if (grf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=aw%0d required=no write (cycle %0d)", grf_aw, cyc);
            end else begin
                b = exp_q.pop_front();
                chk("wb_latency", 32'(cyc), 32'(b.due));
                chk("wb_aw", 32'(grf_aw), 32'(b.aw));
                chk("wb_wd", grf_wd, b.wd);
                chk("wb_pc", grf_pc, b.pc);
            end
        end
    end

    task automatic set_pipe(input logic v, input logic [4:0] aw, input logic [31:0] wd, input logic [31:0] pc);
        pipe_valid = v; pipe_aw = aw; pipe_wd = wd; pipe_pc = pc;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] aw, input logic [31:0] wd, input logic [31:0] pc);
        lu_valid = v; lu_aw = aw; lu_wd = wd; lu_pc = pc;
    endtask

    task automatic set_iss(input logic alloc, input logic [4:0] aw, input logic [4:0] rs, input logic [4:0] rt);
        iss_alloc = alloc; iss_aw = aw; iss_rs = rs; iss_rt = rt;
    endtask

    // One cycle: check comb outputs mid-cycle, queue the beat expected to be
    // accepted at the coming edge, then advance past that edge.
    task automatic step(input string nm, input bit epr, input bit elr, input bit ehz, input bit push);
        beat_t b;
        @(negedge clk);
        chk({nm, " pipe_ready"}, 32'(pipe_ready), 32'(epr));
        chk({nm, " lu_ready"},   32'(lu_ready),   32'(elr));
        chk({nm, " iss_hazard"}, 32'(iss_hazard), 32'(ehz));
        if (push) begin
            if (epr && pipe_aw != 5'd0) begin
                b.aw = pipe_aw; b.wd = pipe_wd; b.pc = pipe_pc; b.due = cyc + 1;
                exp_q.push_back(b);
            end else if (elr && lu_aw != 5'd0) begin
                b.aw = lu_aw; b.wd = lu_wd; b.pc = lu_pc; b.due = cyc + 1;
                exp_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_pipe(0, 0, 0, 0);
        set_lu(0, 0, 0, 0);
        set_iss(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst grf_we", 32'(grf_we), 32'd0);
        chk("rst grf_aw", 32'(grf_aw), 32'd0);
        chk("rst grf_wd", grf_wd, 32'd0);
        chk("rst grf_pc", grf_pc, 32'd0);
        reset = 1'b0;
        step("idle", 0, 0, 0, 1);

        // 1: single pipe beat
        set_pipe(1, 5'd8, 32'h1234, 32'h100);
        step("t1 pipe", 1, 0, 0, 1);
        set_pipe(0, 0, 0, 0);
        step("t1 idle", 0, 0, 0, 1);
        step("t1 idle2", 0, 0, 0, 1);

        // 2: pipe and lu contend
        for (int i = 0; i < 6; i++) begin
            set_pipe(1, 5'(16 + i), 32'h1000 + 32'(i), 32'h2000 + 32'(4 * i));
`ifdef GRF_WB_STARVE_EN
            if (i < 5) set_lu(1, 5'd11, 32'hAAAA, 32'h3000);
            else       set_lu(1, 5'd12, 32'hBBBB, 32'h3004);
            step("t2 arb", i != 4, i == 4, 0, 1);
`else
            set_lu(1, 5'd11, 32'hAAAA, 32'h3000);
            step("t2 arb", 1, 0, 0, 1);
`endif
        end
        set_pipe(0, 0, 0, 0);
        step("t2 lu drain", 0, 1, 0, 1);
        set_lu(0, 0, 0, 0);
        step("t2 idle", 0, 0, 0, 1);

        // 3: RAW hazard until lu commit
        set_iss(1, 5'd5, 0, 0);
        step("t3 alloc", 0, 0, 0, 1);
        set_iss(0, 0, 5'd5, 0);
        step("t3 raw", 0, 0, 1, 1);
        set_lu(1, 5'd5, 32'h5555, 32'h500);
        step("t3 lu accept", 0, 1, 1, 1);
        set_lu(0, 0, 0, 0);
        step("t3 commit", 0, 0, 1, 1);
        step("t3 released", 0, 0, 0, 1);

        // 4: register zero
        set_iss(0, 0, 0, 0);
        set_lu(1, 5'd0, 32'hDEAD, 32'h600);
        step("t4 lu zero", 0, 1, 0, 1);
        set_lu(0, 0, 0, 0);
        set_iss(1, 5'd0, 0, 0);
        step("t4 alloc zero", 0, 0, 0, 1);
        set_iss(0, 0, 0, 0);
        step("t4 read zero", 0, 0, 0, 1);

        // 5: same-edge set and clear, then WAW
        set_lu(1, 5'd7, 32'h7777, 32'h700);
        step("t5 lu accept", 0, 1, 0, 1);
        set_lu(0, 0, 0, 0);
        set_iss(1, 5'd7, 0, 0);
        step("t5 alloc on commit", 0, 0, 0, 1);
        step("t5 waw", 0, 0, 1, 1);
        set_iss(0, 0, 5'd7, 0);
        step("t5 still busy", 0, 0, 1, 1);

        // 6: reset mid-operation
        set_iss(1, 5'd3, 0, 0);
        step("t6 alloc", 0, 0, 0, 1);
        set_iss(0, 0, 5'd3, 5'd7);
        step("t6 raw", 0, 0, 1, 1);
        reset = 1'b1;
        set_pipe(1, 5'd9, 32'hBEEF, 32'h900);
        step("t6 reset edge", 1, 0, 1, 0);
        reset = 1'b0;
        set_pipe(0, 0, 0, 0);
        chk("t6 grf_we", 32'(grf_we), 32'd0);
        chk("t6 grf_aw", 32'(grf_aw), 32'd0);
        step("t6 busy cleared", 0, 0, 0, 1);
        set_iss(0, 0, 0, 0);
        set_pipe(1, 5'd4, 32'h4444, 32'hA00);
        step("t6 pipe after", 1, 0, 0, 1);
        set_pipe(0, 0, 0, 0);
        step("t6 idle", 0, 0, 0, 1);
        step("t6 idle2", 0, 0, 0, 1);

        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
